// File: rtl/variable_packer_pkg.sv
// Shared types for the variable-width lane packer: condition codes,
// config byte layout and the frame-condition matcher.
package variable_packer_pkg;

    typedef enum logic [7:0] {
        COND_NONE      = 8'd0,
        COND_LAST0     = 8'd1,
        COND_NOTLAST0  = 8'd2,
        COND_FIRST0    = 8'd3,
        COND_NOTFIRST0 = 8'd4,
        COND_LAST1     = 8'd5,
        COND_NOTLAST1  = 8'd6,
        COND_FIRST1    = 8'd7,
        COND_NOTFIRST1 = 8'd8
    } cond_e;

    localparam logic [7:0] LEN_DISABLED = 8'd0;

    // Config stream layout, in units of MAX_CHAINS bytes.
    localparam int CFG_COND_BLOCK = 0;
    localparam int CFG_LEN_BLOCK  = 1;
    localparam int CFG_NUM_BLOCKS = 2;

    function automatic logic cond_match(input logic [7:0] code,
                                        input logic [1:0] eof,
                                        input logic [1:0] bof);
        case (code)
            COND_NONE:      return 1'b1;
            COND_LAST0:     return eof[0];
            COND_NOTLAST0:  return !eof[0];
            COND_FIRST0:    return bof[0];
            COND_NOTFIRST0: return !bof[0];
            COND_LAST1:     return eof[1];
            COND_NOTLAST1:  return !eof[1];
            COND_FIRST1:    return bof[1];
            COND_NOTFIRST1: return !bof[1];
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/variable_packer_config.sv
// Per-chain length/condition register files loaded from the byte-serial
// config bus, with a combinational lookup for the selected chain.
module packer_config
    import variable_packer_pkg::*;
#(
    parameter int N                  = 8,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    localparam int CID_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tracing,
    input  logic [7:0]       configId,
    input  logic [7:0]       configData,
    input  logic [CID_W-1:0] chainId_in,
    output logic [7:0]       chain_len,
    output logic [7:0]       chain_cond,
    output logic             chain_commit
);

    localparam logic [7:0] CFG_ID    = 8'(PERSONAL_CONFIG_ID);
    localparam logic [7:0] CFG_END   = 8'(CFG_NUM_BLOCKS * MAX_CHAINS);
    localparam logic [7:0] LEN_RESET = 8'(N);

    logic [7:0] len_q  [MAX_CHAINS];
    logic [7:0] len_d  [MAX_CHAINS];
    logic [7:0] cond_q [MAX_CHAINS];
    logic [7:0] cond_d [MAX_CHAINS];
    logic [7:0] byte_counter_q, byte_counter_d;

    // The counter parks at CFG_END so trailing bytes cannot wrap around.
    always_comb begin
        len_d          = len_q;
        cond_d         = cond_q;
        byte_counter_d = byte_counter_q;
        if (!tracing) begin
            if (configId == CFG_ID) begin
                for (int i = 0; i < MAX_CHAINS; i++) begin
                    if (byte_counter_q == 8'(CFG_COND_BLOCK * MAX_CHAINS + i))
                        cond_d[i] = configData;
                    if (byte_counter_q == 8'(CFG_LEN_BLOCK * MAX_CHAINS + i))
                        len_d[i] = configData;
                end
                if (byte_counter_q != CFG_END)
                    byte_counter_d = byte_counter_q + 8'd1;
            end else begin
                byte_counter_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_CHAINS; i++) begin
                len_q[i]  <= LEN_RESET;
                cond_q[i] <= COND_NONE;
            end
            byte_counter_q <= '0;
        end else begin
            len_q          <= len_d;
            cond_q         <= cond_d;
            byte_counter_q <= byte_counter_d;
        end
    end

    generate
        if ((1 << CID_W) == MAX_CHAINS) begin : g_full_index
            assign chain_len  = len_q[chainId_in];
            assign chain_cond = cond_q[chainId_in];
        end else begin : g_guarded_index
            assign chain_len  = (32'(chainId_in) < MAX_CHAINS) ? len_q[chainId_in]  : LEN_DISABLED;
            assign chain_cond = (32'(chainId_in) < MAX_CHAINS) ? cond_q[chainId_in] : 8'hFF;
        end
    endgenerate

    assign chain_commit = (chain_len != LEN_DISABLED) && (chain_len <= LEN_RESET);

endmodule

// File: rtl/variable_packer.sv
// Packs the first L lanes of qualifying beats into dense N-lane output
// vectors, carrying the remainder between beats; flush emits the partial tail.
module variable_packer
    import variable_packer_pkg::*;
#(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    localparam int CID_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tracing,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [1:0]              eof_in,
    input  logic [1:0]              bof_in,
    input  logic [CID_W-1:0]        chainId_in,
    input  logic [7:0]              configId,
    input  logic [7:0]              configData,
    input  logic [N*DATA_WIDTH-1:0] vector_in,
    input  logic                    flush_in,
    output logic [N*DATA_WIDTH-1:0] vector_out,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [CNT_W-1:0]        lanes_out
);

    localparam logic [8:0] N9 = 9'(N);

    logic [7:0] cfg_len, cfg_cond;
    logic       cfg_commit;

    packer_config #(
        .N                 (N),
        .MAX_CHAINS        (MAX_CHAINS),
        .PERSONAL_CONFIG_ID(PERSONAL_CONFIG_ID)
    ) u_config (
        .clk         (clk),
        .rst         (rst),
        .tracing     (tracing),
        .configId    (configId),
        .configData  (configData),
        .chainId_in  (chainId_in),
        .chain_len   (cfg_len),
        .chain_cond  (cfg_cond),
        .chain_commit(cfg_commit)
    );

    logic [DATA_WIDTH-1:0]   in_lane   [N];
    logic [DATA_WIDTH-1:0]   buf_q     [N];
    logic [DATA_WIDTH-1:0]   buf_d     [N];
    logic [DATA_WIDTH-1:0]   comb_lane [2*N];
    logic [N*DATA_WIDTH-1:0] vout_q, vout_d;
    logic [CNT_W-1:0]        count_q, count_d, lanes_q, lanes_d;
    logic                    valid_q, valid_d;
    logic                    flush_pending_q, flush_pending_d;
    logic [8:0]              cnt9, len9, total;
    logic                    out_free, accept, pack;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign in_lane[gi] = vector_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign out_free = !valid_q || ready_out;
    assign ready_in = out_free && !flush_pending_q;
    assign accept   = valid_in && ready_in;
    assign pack     = accept && tracing && cfg_commit
                      && cond_match(cfg_cond, eof_in, bof_in);

    assign cnt9  = 9'(count_q);
    assign len9  = {1'b0, cfg_len};
    assign total = cnt9 + len9;

    // Buffered lanes followed by the new beat's first L lanes; 2N slots
    // cover the worst case of N-1 held lanes plus a full beat.
    always_comb begin
        for (int i = 0; i < 2*N; i++)
            comb_lane[i] = '0;
        for (int i = 0; i < N; i++)
            if (9'(i) < cnt9)
                comb_lane[i] = buf_q[i];
        for (int i = 0; i < 2*N; i++)
            for (int j = 0; j < N; j++)
                if ((9'(i) == cnt9 + 9'(j)) && (9'(j) < len9))
                    comb_lane[i] = in_lane[j];
    end

    always_comb begin
        buf_d           = buf_q;
        count_d         = count_q;
        vout_d          = vout_q;
        lanes_d         = lanes_q;
        valid_d         = valid_q && !ready_out;
        flush_pending_d = flush_pending_q || flush_in;
        if (pack) begin
            if (total >= N9) begin
                for (int i = 0; i < N; i++) begin
                    vout_d[i*DATA_WIDTH +: DATA_WIDTH] = comb_lane[i];
                    buf_d[i] = comb_lane[i+N];
                end
                lanes_d = CNT_W'(N);
                valid_d = 1'b1;
                count_d = CNT_W'(total - N9);
            end else begin
                for (int i = 0; i < N; i++)
                    buf_d[i] = comb_lane[i];
                count_d = CNT_W'(total);
            end
        end else if (flush_pending_q && out_free) begin
            flush_pending_d = flush_in;
            if (count_q != '0) begin
                for (int i = 0; i < N; i++) begin
                    vout_d[i*DATA_WIDTH +: DATA_WIDTH] = (9'(i) < cnt9) ? buf_q[i] : '0;
                    buf_d[i] = '0;
                end
                lanes_d = count_q;
                valid_d = 1'b1;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                buf_q[i] <= '0;
            count_q         <= '0;
            vout_q          <= '0;
            lanes_q         <= '0;
            valid_q         <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            buf_q           <= buf_d;
            count_q         <= count_d;
            vout_q          <= vout_d;
            lanes_q         <= lanes_d;
            valid_q         <= valid_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign vector_out = vout_q;
    assign valid_out  = valid_q;
    assign lanes_out  = lanes_q;

endmodule

// File: tb/tb_variable_packer.sv
// Directed-vector bench for variable_packer (N=8, 32-bit lanes, 4 chains).
module tb_variable_packer;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int MC  = 4;
    localparam int PID = 0;

    logic            clk, rst, tracing, valid_in, ready_in, flush_in;
    logic            valid_out, ready_out;
    logic [1:0]      eof_in, bof_in, chainId_in;
    logic [7:0]      configId, configData;
    logic [N*DW-1:0] vector_in, vector_out;
    logic [3:0]      lanes_out;

    int tests_run    = 0;
    int tests_failed = 0;

    variable_packer #(
        .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(PID)
    ) dut (
        .clk(clk), .rst(rst), .tracing(tracing),
        .valid_in(valid_in), .ready_in(ready_in),
        .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
        .configId(configId), .configData(configData),
        .vector_in(vector_in), .flush_in(flush_in),
        .vector_out(vector_out), .valid_out(valid_out),
        .ready_out(ready_out), .lanes_out(lanes_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lanes start..start+n-1, remaining lanes zero.
    function automatic logic [N*DW-1:0] mk_vec(input int start, input int n);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v[i*DW +: DW] = 32'(start + i);
        return v;
    endfunction

    // Three meaningful lanes a..a+2, junk in the lanes that must be ignored.
    function automatic logic [N*DW-1:0] beat3(input int a);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++)
            v[i*DW +: DW] = (i < 3) ? 32'(a + i) : 32'hDEAD_0000 + 32'(i);
        return v;
    endfunction

    // Byte 0 is the LSB of cfg.
    task automatic configure(input logic [63:0] cfg);
        valid_in = 1'b0;
        tracing  = 1'b0;
        configId = 8'(PID);
        for (int k = 0; k < 8; k++) begin
            configData = cfg[k*8 +: 8];
            step();
        end
        configId = 8'hFF;
        step();
        tracing = 1'b1;
    endtask

    task automatic idle();
        valid_in  = 1'b0;
        flush_in  = 1'b0;
        ready_out = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        tests_run++;
        if (lanes_out !== 4'd0) begin tests_failed++; $display("FAIL reset_lanes: got %0d expected 0", lanes_out); end
        tests_run++;
        if (vector_out !== '0) begin tests_failed++; $display("FAIL reset_vector: got %h expected 0", vector_out); end
        tests_run++;
        if (dut.count_q !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", dut.count_q); end
        rst = 1'b0;
        step();
        tests_run++;
        if (ready_in !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_in: got %b expected 1", ready_in); end
        $display("[TB] reset: done");
    endtask

    task automatic test_pack_three();
        idle();
        configure({8'd8, 8'd8, 8'd8, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0});
        chainId_in = 2'd0;
        valid_in   = 1'b1;
        vector_in  = beat3(1);
        step();
        tests_run++;
        if (dut.count_q !== 4'd3) begin tests_failed++; $display("FAIL pack3_count1: got %0d expected 3", dut.count_q); end
        vector_in = beat3(4);
        step();
        tests_run++;
        if (dut.count_q !== 4'd6 || valid_out !== 1'b0) begin tests_failed++; $display("FAIL pack3_count2: got count %0d valid %b expected 6 / 0", dut.count_q, valid_out); end
        vector_in = beat3(7);
        step();
        valid_in = 1'b0;
        tests_run++;
        if (valid_out !== 1'b1 || vector_out !== mk_vec(1, 8)) begin tests_failed++; $display("FAIL pack3_emit: got valid %b vec %h expected 1 / %h", valid_out, vector_out, mk_vec(1, 8)); end
        tests_run++;
        if (lanes_out !== 4'd8 || dut.count_q !== 4'd1) begin tests_failed++; $display("FAIL pack3_lanes: got lanes %0d count %0d expected 8 / 1", lanes_out, dut.count_q); end
        $display("[TB] pack3: emitted %h lanes %0d", vector_out, lanes_out);
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        for (int c = 0; c < 5 && valid_out !== 1'b1; c++) step();
        tests_run++;
        if (valid_out !== 1'b1 || vector_out !== mk_vec(9, 1) || lanes_out !== 4'd1) begin tests_failed++; $display("FAIL pack3_flush: got valid %b vec %h lanes %0d expected 1 / %h / 1", valid_out, vector_out, lanes_out, mk_vec(9, 1)); end
        tests_run++;
        if (dut.count_q !== 4'd0) begin tests_failed++; $display("FAIL pack3_flush_count: got %0d expected 0", dut.count_q); end
        $display("[TB] pack3 flush: %h lanes %0d", vector_out, lanes_out);
    endtask

    task automatic test_full_lane();
        idle();
        configure({8'd8, 8'd8, 8'd8, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0});
        valid_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            vector_in = mk_vec(k * 100, 8);
            step();
            tests_run++;
            if (valid_out !== 1'b1 || vector_out !== mk_vec(k * 100, 8) || lanes_out !== 4'd8 || dut.count_q !== 4'd0) begin
                tests_failed++;
                $display("FAIL full_lane_%0d: got valid %b vec %h lanes %0d count %0d expected 1 / %h / 8 / 0", k, valid_out, vector_out, lanes_out, dut.count_q, mk_vec(k * 100, 8));
            end
            $display("[TB] full_lane beat %0d: out %h", k, vector_out);
        end
        valid_in = 1'b0;
    endtask

    task automatic test_backpressure();
        idle();
        ready_out = 1'b0;
        valid_in  = 1'b1;
        vector_in = mk_vec(500, 8);
        step();
        valid_in  = 1'b0;
        vector_in = mk_vec(900, 8);
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (ready_in !== 1'b0 || valid_out !== 1'b1 || vector_out !== mk_vec(500, 8) || lanes_out !== 4'd8) begin
                tests_failed++;
                $display("FAIL stall_%0d: got ready_in %b valid %b vec %h lanes %0d expected 0 / 1 / %h / 8", c, ready_in, valid_out, vector_out, lanes_out, mk_vec(500, 8));
            end
            step();
        end
        ready_out = 1'b1;
        #1;
        tests_run++;
        if (ready_in !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready: got %b expected 1", ready_in); end
        step();
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL stall_release_valid: got %b expected 0", valid_out); end
        $display("[TB] backpressure: released");
    endtask

    task automatic test_condition();
        idle();
        configure({8'd8, 8'd8, 8'd8, 8'd3, 8'd0, 8'd0, 8'd0, 8'd1});
        valid_in  = 1'b1;
        eof_in    = 2'b00;
        vector_in = beat3(20);
        step();
        tests_run++;
        if (dut.count_q !== 4'd0) begin tests_failed++; $display("FAIL cond_drop_a: got count %0d expected 0", dut.count_q); end
        eof_in    = 2'b10;
        vector_in = beat3(30);
        step();
        tests_run++;
        if (dut.count_q !== 4'd0) begin tests_failed++; $display("FAIL cond_drop_b: got count %0d expected 0", dut.count_q); end
        eof_in    = 2'b01;
        vector_in = beat3(40);
        step();
        valid_in = 1'b0;
        eof_in   = 2'b00;
        tests_run++;
        if (dut.count_q !== 4'd3 || valid_out !== 1'b0) begin tests_failed++; $display("FAIL cond_pack: got count %0d valid %b expected 3 / 0", dut.count_q, valid_out); end
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        for (int c = 0; c < 5 && valid_out !== 1'b1; c++) step();
        tests_run++;
        if (valid_out !== 1'b1 || vector_out !== mk_vec(40, 3) || lanes_out !== 4'd3) begin tests_failed++; $display("FAIL cond_flush: got valid %b vec %h lanes %0d expected 1 / %h / 3", valid_out, vector_out, lanes_out, mk_vec(40, 3)); end
        $display("[TB] condition: flush %h lanes %0d", vector_out, lanes_out);
    endtask

    task automatic test_config();
        idle();
        // A stray byte then a foreign configId: the counter must restart at 0.
        tracing    = 1'b0;
        configId   = 8'(PID);
        configData = 8'd1;
        step();
        configId   = 8'h33;
        configData = 8'h77;
        step();
        configure({8'd8, 8'd8, 8'd8, 8'd5, 8'd0, 8'd0, 8'd0, 8'd2});
        chainId_in = 2'd0;
        valid_in   = 1'b1;
        eof_in     = 2'b01;
        vector_in  = mk_vec(60, 8);
        step();
        tests_run++;
        if (dut.count_q !== 4'd0) begin tests_failed++; $display("FAIL config_drop: got count %0d expected 0", dut.count_q); end
        eof_in    = 2'b00;
        vector_in = mk_vec(70, 8);
        step();
        valid_in = 1'b0;
        tests_run++;
        if (dut.count_q !== 4'd5 || valid_out !== 1'b0) begin tests_failed++; $display("FAIL config_len5: got count %0d valid %b expected 5 / 0", dut.count_q, valid_out); end
        $display("[TB] config: count %0d", dut.count_q);
    endtask

    task automatic test_reset_mid();
        tracing   = 1'b0;
        configId  = 8'hFF;
        valid_in  = 1'b1;
        eof_in    = 2'b00;
        vector_in = mk_vec(80, 8);
        step();
        valid_in = 1'b0;
        tracing  = 1'b1;
        tests_run++;
        if (dut.count_q !== 4'd5 || valid_out !== 1'b0) begin tests_failed++; $display("FAIL cfgmode_hold: got count %0d valid %b expected 5 / 0", dut.count_q, valid_out); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (dut.count_q !== 4'd0 || valid_out !== 1'b0) begin tests_failed++; $display("FAIL midreset: got count %0d valid %b expected 0 / 0", dut.count_q, valid_out); end
        step();
        rst = 1'b0;
        step();
        valid_in  = 1'b1;
        vector_in = mk_vec(700, 8);
        step();
        valid_in = 1'b0;
        tests_run++;
        if (valid_out !== 1'b1 || vector_out !== mk_vec(700, 8) || lanes_out !== 4'd8) begin tests_failed++; $display("FAIL midreset_beat: got valid %b vec %h lanes %0d expected 1 / %h / 8", valid_out, vector_out, lanes_out, mk_vec(700, 8)); end
        $display("[TB] reset_mid: out %h", vector_out);
    endtask

    task automatic test_flush_coincide();
        idle();
        configure({8'd8, 8'd8, 8'd3, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0});
        chainId_in = 2'd1;
        valid_in   = 1'b1;
        flush_in   = 1'b1;
        vector_in  = beat3(50);
        step();
        valid_in = 1'b0;
        flush_in = 1'b0;
        tests_run++;
        if (dut.count_q !== 4'd3 || valid_out !== 1'b0 || ready_in !== 1'b0) begin tests_failed++; $display("FAIL coincide_beat: got count %0d valid %b ready_in %b expected 3 / 0 / 0", dut.count_q, valid_out, ready_in); end
        for (int c = 0; c < 5 && valid_out !== 1'b1; c++) step();
        tests_run++;
        if (valid_out !== 1'b1 || vector_out !== mk_vec(50, 3) || lanes_out !== 4'd3) begin tests_failed++; $display("FAIL coincide_flush: got valid %b vec %h lanes %0d expected 1 / %h / 3", valid_out, vector_out, lanes_out, mk_vec(50, 3)); end
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        step();
        step();
        tests_run++;
        if (valid_out !== 1'b0 || ready_in !== 1'b1) begin tests_failed++; $display("FAIL empty_flush: got valid %b ready_in %b expected 0 / 1", valid_out, ready_in); end
        $display("[TB] flush_coincide: done");
    endtask

    initial begin
        rst        = 1'b1;
        tracing    = 1'b1;
        valid_in   = 1'b0;
        eof_in     = 2'b00;
        bof_in     = 2'b00;
        chainId_in = 2'd0;
        configId   = 8'hFF;
        configData = 8'd0;
        vector_in  = '0;
        flush_in   = 1'b0;
        ready_out  = 1'b1;
        step();
        step();
        test_reset();
        test_pack_three();
        test_full_lane();
        test_backpressure();
        test_condition();
        test_config();
        test_reset_mid();
        test_flush_coincide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/variable_packer.md
VARIABLE_PACKER -- requirements
Module: variable_packer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning lanes per vector.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning bits per lane.
REQ-003 The block SHALL have parameter MAX_CHAINS, default 4, meaning the number of independent per-chain configurations.
REQ-004 The block SHALL have parameter PERSONAL_CONFIG_ID, default 0, meaning the configId value this block answers to.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit, reset; rst is asynchronous and active-high.
REQ-007 The block SHALL have port tracing, input, 1 bit: 1 = trace mode, 0 = configuration mode.
REQ-008 The block SHALL have port valid_in, input, 1 bit, input beat present.
REQ-009 The block SHALL have port ready_in, output, 1 bit, input beat accepted when valid_in and ready_in are both 1.
REQ-010 The block SHALL have ports eof_in and bof_in, input, 2 bits each, end-of-frame and beginning-of-frame flags per nesting level.
REQ-011 The block SHALL have port chainId_in, input, clog2(MAX_CHAINS) bits, selecting the chain configuration.
REQ-012 The block SHALL have ports configId and configData, input, 8 bits each, the configuration bus.
REQ-013 The block SHALL have port vector_in, input, N x DATA_WIDTH, the input lanes.
REQ-014 The block SHALL have port flush_in, input, 1 bit, a request to emit the partial buffer.
REQ-015 The block SHALL have port vector_out, output, N x DATA_WIDTH, the packed lanes.
REQ-016 The block SHALL have port valid_out, output, 1 bit, meaning vector_out holds a vector.
REQ-017 The block SHALL have port ready_out, input, 1 bit, downstream acceptance.
REQ-018 The block SHALL have port lanes_out, output, clog2(N+1) bits, the number of meaningful lanes in vector_out.

Function
REQ-019 Each chain SHALL hold an 8-bit length L: 0 = disabled; 1..N = use lanes vector_in[0..L-1]; values above N are treated as disabled.
REQ-020 Each chain SHALL hold an 8-bit condition code, 0..8: none; eof[0]=1; eof[0]=0; bof[0]=1; bof[0]=0; then the same four tests on index 1. Any other code SHALL never match.
REQ-021 A beat SHALL be packed only when tracing=1, the beat is accepted, L is in 1..N and the condition matches; otherwise it SHALL be consumed and dropped.
REQ-022 The buffer SHALL hold count lanes, 0..N-1, at indices 0..count-1; a packed beat's lanes SHALL be appended at index count onward, preserving order.
REQ-023 If count+L < N, the block SHALL store the appended lanes and emit nothing.
REQ-024 If count+L >= N, the block SHALL emit the first N lanes with lanes_out=N, shift the remaining count+L-N lanes down to index 0, and set count to that remainder. This packing SHALL be lossless, with no spill-as-is.
REQ-025 Output SHALL be registered: the vector SHALL appear on the cycle after the accepting edge.
REQ-026 ready_in SHALL equal (!valid_out || ready_out) && !flush_pending.
REQ-027 valid_out, vector_out and lanes_out SHALL hold stable while valid_out=1 and ready_out=0.
REQ-028 valid_out SHALL clear after a cycle with ready_out=1, unless a new vector is emitted on the same edge.
REQ-029 On flush_in=1, flush_pending SHALL set and take priority over new beats. When the output register is free, the block SHALL:
  - if count>0: emit lanes 0..count-1 with lanes 0..count-1 valid, lanes count..N-1 zero, lanes_out=count, then set count to 0;
  - if count=0: emit nothing.
  In both cases flush_pending SHALL then clear.
REQ-030 When flush_in and an accepted beat coincide, the beat SHALL be processed first and the flush SHALL execute afterwards.
REQ-031 In configuration mode (tracing=0) with configId=PERSONAL_CONFIG_ID, byte_counter SHALL increment once per cycle:
  - bytes 0..MAX_CHAINS-1 write cond[byte_counter];
  - bytes MAX_CHAINS..2*MAX_CHAINS-1 write length[byte_counter-MAX_CHAINS];
  - later bytes are ignored.
REQ-032 In configuration mode with configId not equal to PERSONAL_CONFIG_ID, byte_counter SHALL reset to 0.
REQ-033 Configuration mode SHALL NOT alter count or buffer contents.
REQ-034 Any output still pending at the switch to configuration mode SHALL still drain.

Reset
REQ-035 On rst the block SHALL asynchronously clear valid_out=0, vector_out=0, lanes_out=0, count=0, buffer=0, flush_pending=0 and byte_counter=0.
REQ-036 On rst every chain's length SHALL become N and every condition code SHALL become 0.
REQ-037 Reset asserted mid-operation SHALL discard partial data with no output.

Structure
REQ-038 Package variable_packer_pkg SHALL hold the condition-code enum (COND_NONE..COND_NOTFIRST1), the LEN_DISABLED constant and the config-byte layout offsets.
REQ-039 Sub-module packer_config SHALL hold the config register files and byte_counter, and provide combinational length, condition and commit outputs per chainId_in.

Verification
REQ-040 With N=8, chain0 L=3, cond 0, and beats {1,2,3}, {4,5,6}, {7,8,9}: the third beat SHALL produce vector_out={1..8}, lanes_out=8, count=1; a following flush SHALL give {9,0,0,0,0,0,0,0} with lanes_out=1.
REQ-041 With L=8 and consecutive beats of distinct values, vector_out SHALL match each beat exactly one cycle later, and count SHALL stay 0.
REQ-042 With ready_out=0 while valid_out=1: ready_in=0, vector_out SHALL be unchanged for 5 cycles, and the data SHALL be released on the first ready_out=1.
REQ-043 With cond=1, beats with eof_in[0]=0 SHALL be dropped (count unchanged) and the beat with eof_in[0]=1 SHALL be packed.
REQ-044 Config stream: bytes {2,0,0,0,5,8,8,8} at PERSONAL_CONFIG_ID SHALL set chain0 to cond=2 and L=5.
REQ-045 Asserting rst with count=5 mid-stream: count SHALL be 0, valid_out SHALL be 0, and the next 8-lane beat SHALL emit unchanged.
